// File: rtl/pi_loop_filter_pkg.sv
// Shared types, default parameters and arithmetic helpers for the PI loop filter.
package pi_loop_filter_pkg;

    localparam int unsigned W_DEF          = 8;
    localparam int unsigned FRAC_DEF       = 4;
    localparam int unsigned RESET_VAL_DEF  = 128;
    localparam int unsigned KP_ACQ_DEF     = 4;
    localparam int unsigned KP_TRK_DEF     = 1;
    localparam int unsigned KI_ACQ_DEF     = 16;
    localparam int unsigned KI_TRK_DEF     = 2;
    localparam int unsigned LOCK_CNT_DEF   = 16;
    localparam int unsigned UNLOCK_RUN_DEF = 8;

    typedef enum logic {
        ACQ   = 1'b0,
        TRACK = 1'b1
    } state_t;

    // Phase error: +1 oscillator slow, -1 oscillator fast, 0 no information.
    typedef logic signed [1:0] err_t;

    // a + d clamped to [0, hi]; operands are small enough that int never overflows.
    function automatic int sat_add(input int a, input int d, input int hi);
        int s;
        s = a + d;
        if (s < 0) begin
            return 0;
        end
        if (s > hi) begin
            return hi;
        end
        return s;
    endfunction

endpackage

// File: rtl/pi_loop_filter_if.sv
// Phase-detector / control-word bundle between the PD side and the loop filter.
interface pi_loop_filter_if #(
    parameter int unsigned W = 8
) ();
    logic         up;
    logic         dn;
    logic         freeze;
    logic         load;
    logic [W-1:0] load_val;
    logic [W-1:0] speed_var;
    logic         locked;
    logic [W-1:0] acc_int;

    modport master (
        output up, dn, freeze, load, load_val,
        input  speed_var, locked, acc_int
    );

    modport slave (
        input  up, dn, freeze, load, load_val,
        output speed_var, locked, acc_int
    );
endinterface

// File: rtl/pi_loop_filter_lock_detector.sv
// Lock detector: counts quiet/dither cycles and same-direction runs, switches ACQ/TRACK.
module pi_loop_filter_lock_detector
    import pi_loop_filter_pkg::*;
#(
    parameter int unsigned LOCK_CNT   = LOCK_CNT_DEF,
    parameter int unsigned UNLOCK_RUN = UNLOCK_RUN_DEF
) (
    input  logic clk,
    input  logic rst,
    input  err_t err_i,
    input  logic freeze_i,
    input  logic clear_i,
    output logic locked_o
);

    localparam int unsigned QW = $clog2(LOCK_CNT + 1);
    localparam int unsigned RW = $clog2(UNLOCK_RUN + 1);

    state_t        state_q;
    logic          locked_q;
    logic [QW-1:0] quiet_q;
    logic [RW-1:0] run_q;
    err_t          last_err_q;

    logic          same_dir_c;
    logic [QW-1:0] quiet_upd_c;
    logic [RW-1:0] run_upd_c;

    // Counter updates for a normal cycle, before any state-entry clear.
    always_comb begin
        same_dir_c  = (err_i != 2'sd0) && (err_i == last_err_q);
        quiet_upd_c = quiet_q;
        run_upd_c   = run_q;
        if (same_dir_c) begin
            quiet_upd_c = '0;
            run_upd_c   = (run_q == RW'(UNLOCK_RUN)) ? run_q : run_q + RW'(1);
        end else begin
            quiet_upd_c = (quiet_q == QW'(LOCK_CNT)) ? quiet_q : quiet_q + QW'(1);
            run_upd_c   = RW'(err_i != 2'sd0);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ACQ;
            locked_q   <= 1'b0;
            quiet_q    <= '0;
            run_q      <= '0;
            last_err_q <= 2'sd0;
        end else if (clear_i) begin
            state_q    <= ACQ;
            locked_q   <= 1'b0;
            quiet_q    <= '0;
            run_q      <= '0;
            last_err_q <= 2'sd0;
        end else if (!freeze_i) begin
            if (err_i != 2'sd0) begin
                last_err_q <= err_i;
            end
            quiet_q <= quiet_upd_c;
            run_q   <= run_upd_c;
            case (state_q)
                ACQ: begin
                    if (quiet_upd_c == QW'(LOCK_CNT)) begin
                        state_q  <= TRACK;
                        locked_q <= 1'b1;
                        quiet_q  <= '0;
                        run_q    <= '0;
                    end
                end
                TRACK: begin
                    if (run_upd_c == RW'(UNLOCK_RUN)) begin
                        state_q  <= ACQ;
                        locked_q <= 1'b0;
                        quiet_q  <= '0;
                        run_q    <= '0;
                    end
                end
                default: begin
                    state_q  <= ACQ;
                    locked_q <= 1'b0;
                end
            endcase
        end
    end

    assign locked_o = locked_q;

endmodule

// File: rtl/pi_loop_filter.sv
// PI loop filter: PD up/dn to saturating fractional integrator plus proportional kick.
module pi_loop_filter
    import pi_loop_filter_pkg::*;
#(
    parameter int unsigned W          = W_DEF,
    parameter int unsigned FRAC       = FRAC_DEF,
    parameter int unsigned RESET_VAL  = RESET_VAL_DEF,
    parameter int unsigned KP_ACQ     = KP_ACQ_DEF,
    parameter int unsigned KP_TRK     = KP_TRK_DEF,
    parameter int unsigned KI_ACQ     = KI_ACQ_DEF,
    parameter int unsigned KI_TRK     = KI_TRK_DEF,
    parameter int unsigned LOCK_CNT   = LOCK_CNT_DEF,
    parameter int unsigned UNLOCK_RUN = UNLOCK_RUN_DEF
) (
    input  logic              clk,
    input  logic              rst,
    pi_loop_filter_if.slave   pll_if
);

    localparam int unsigned AW      = W + FRAC;
    localparam int unsigned SW      = W + 2;
    localparam int unsigned ACC_MAX = (2 ** AW) - 1;
    localparam int unsigned SPD_MAX = (2 ** W) - 1;

    logic [AW-1:0]        acc_q, acc_d;
    logic [W-1:0]         speed_q, speed_d;
    logic                 locked;
    err_t                 err_c;
    int unsigned          ki_c;
    int unsigned          kp_c;
    logic [AW-1:0]        acc_sat_c;
    logic signed [SW-1:0] kick_s_c;
    logic [W-1:0]         speed_clamp_c;

    // Error decode; simultaneous up and dn carry no information.
    always_comb begin
        err_c = 2'sd0;
        if (pll_if.up && !pll_if.dn) begin
            err_c = 2'sd1;
        end else if (pll_if.dn && !pll_if.up) begin
            err_c = -2'sd1;
        end
    end

    // Gain mux follows the registered lock state, so a switch lands one cycle after the transition.
    always_comb begin
        ki_c = locked ? KI_TRK : KI_ACQ;
        kp_c = locked ? KP_TRK : KP_ACQ;
    end

    always_comb begin
        acc_sat_c = AW'(sat_add(int'(acc_q), int'(err_c) * int'(ki_c), int'(ACC_MAX)));
        kick_s_c  = $signed({2'b00, acc_sat_c[AW-1:FRAC]})
                  + $signed(SW'(int'(err_c) * int'(kp_c)));
        if (kick_s_c < 0) begin
            speed_clamp_c = '0;
        end else if (kick_s_c > $signed(SW'(SPD_MAX))) begin
            speed_clamp_c = W'(SPD_MAX);
        end else begin
            speed_clamp_c = W'(kick_s_c);
        end
    end

    // Load beats freeze beats normal update.
    always_comb begin
        acc_d   = acc_q;
        speed_d = speed_q;
        if (pll_if.load) begin
            acc_d   = {pll_if.load_val, {FRAC{1'b0}}};
            speed_d = pll_if.load_val;
        end else if (!pll_if.freeze) begin
            acc_d   = acc_sat_c;
            speed_d = speed_clamp_c;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q   <= AW'(RESET_VAL << FRAC);
            speed_q <= W'(RESET_VAL);
        end else begin
            acc_q   <= acc_d;
            speed_q <= speed_d;
        end
    end

    pi_loop_filter_lock_detector #(
        .LOCK_CNT   (LOCK_CNT),
        .UNLOCK_RUN (UNLOCK_RUN)
    ) u_lock_detector (
        .clk      (clk),
        .rst      (rst),
        .err_i    (err_c),
        .freeze_i (pll_if.freeze),
        .clear_i  (pll_if.load),
        .locked_o (locked)
    );

    assign pll_if.speed_var = speed_q;
    assign pll_if.acc_int   = acc_q[AW-1:FRAC];
    assign pll_if.locked    = locked;

endmodule

// File: tb/tb_pi_loop_filter.sv
// Scoreboard bench for pi_loop_filter: directed scenarios plus randomized up/dn/freeze/load traffic.
module tb_pi_loop_filter;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    pi_loop_filter_if #(.W(8)) bus ();

    pi_loop_filter dut (
        .clk    (clk),
        .rst    (rst),
        .pll_if (bus)
    );

    typedef struct {
        int spd;
        int ai;
        int lk;
    } exp_t;

    exp_t sbq[$];
    int   compared   = 0;
    int   mismatched = 0;

    // Reference state kept as plain integers.
    int m_acc, m_spd, m_lk, m_quiet, m_run, m_last;

    task automatic check(input string nm, input int act, input int exp);
        compared++;
        if (act != exp) begin
            mismatched++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_acc = 128 * 16; m_spd = 128; m_lk = 0;
        m_quiet = 0; m_run = 0; m_last = 0;
    endtask

    task automatic model_step(input bit u, input bit d, input bit f, input bit l, input int lv);
        int e, ki, kp;
        if (l) begin
            m_acc = lv * 16; m_spd = lv; m_lk = 0;
            m_quiet = 0; m_run = 0; m_last = 0;
        end else if (!f) begin
            e  = (u && !d) ? 1 : ((d && !u) ? -1 : 0);
            ki = m_lk ? 2 : 16;
            kp = m_lk ? 1 : 4;
            m_acc = m_acc + e * ki;
            if (m_acc < 0) m_acc = 0;
            if (m_acc > 4095) m_acc = 4095;
            m_spd = m_acc / 16 + e * kp;
            if (m_spd < 0) m_spd = 0;
            if (m_spd > 255) m_spd = 255;
            if (e != 0 && e == m_last) begin
                m_run = (m_run < 8) ? m_run + 1 : 8;
                m_quiet = 0;
            end else begin
                m_quiet = (m_quiet < 16) ? m_quiet + 1 : 16;
                m_run = (e != 0) ? 1 : 0;
            end
            if (e != 0) m_last = e;
            if (!m_lk && m_quiet == 16) begin
                m_lk = 1; m_quiet = 0; m_run = 0;
            end else if (m_lk && m_run == 8) begin
                m_lk = 0; m_quiet = 0; m_run = 0;
            end
        end
    endtask

    // Called at a negedge: drive one cycle, predict its result, return at the next negedge.
    task automatic cyc(input bit u, input bit d, input bit f, input bit l, input int lv);
        exp_t e;
        bus.up = u; bus.dn = d; bus.freeze = f; bus.load = l; bus.load_val = 8'(lv);
        model_step(u, d, f, l, lv);
        e.spd = m_spd; e.ai = m_acc / 16; e.lk = m_lk;
        sbq.push_back(e);
        @(negedge clk);
    endtask

    task automatic chk_now(input string nm, input int s, input int a, input int l);
        if (s >= 0) check({nm, "_speed"}, int'(bus.speed_var), s);
        if (a >= 0) check({nm, "_acc"}, int'(bus.acc_int), a);
        if (l >= 0) check({nm, "_locked"}, int'(bus.locked), l);
    endtask

    // Async reset between edges; outputs must change without waiting for a clock.
    task automatic async_reset(input string nm);
        #1 rst = 1'b1;
        bus.up = 1'b0; bus.dn = 1'b0; bus.freeze = 1'b0; bus.load = 1'b0;
        #1 chk_now(nm, 128, 128, 0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Monitor: pops one prediction per active edge that had stimulus.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #2;
            if (sbq.size() > 0) begin
                e = sbq.pop_front();
                check("sb_speed", int'(bus.speed_var), e.spd);
                check("sb_acc", int'(bus.acc_int), e.ai);
                check("sb_locked", int'(bus.locked), e.lk);
            end
        end
    end

    initial begin
        int mode;
        bit u, d, f, l;
        int lv;

        rst = 1'b1;
        bus.up = 1'b0; bus.dn = 1'b0; bus.freeze = 1'b0; bus.load = 1'b0; bus.load_val = '0;
        model_reset();
        repeat (2) @(negedge clk);
        chk_now("reset", 128, 128, 0);
        rst = 1'b0;

        // Proportional kick plus integration in ACQ.
        cyc(1, 0, 0, 0, 0); chk_now("up1", 133, 129, 0);
        cyc(1, 0, 0, 0, 0); chk_now("up2", 134, 130, 0);
        cyc(1, 0, 0, 0, 0); chk_now("up3", 135, 131, 0);
        cyc(0, 0, 0, 0, 0); chk_now("release", 131, 131, 0);
        async_reset("midrst");

        // Saturation at both ends.
        cyc(0, 0, 0, 1, 254);
        for (int i = 0; i < 40; i++) cyc(1, 0, 0, 0, 0);
        chk_now("sat_hi", 255, 255, -1);
        cyc(0, 0, 0, 1, 1);
        for (int i = 0; i < 40; i++) cyc(0, 1, 0, 0, 0);
        chk_now("sat_lo", 0, 0, 0);

        // Dither to lock, then a same-direction run to unlock.
        for (int i = 0; i < 16; i++) begin
            cyc(i % 2 == 0, i % 2 == 1, 0, 0, 0);
            if (i == 14) chk_now("dither15", -1, -1, 0);
        end
        chk_now("dither16", -1, -1, 1);
        cyc(1, 0, 0, 0, 0); chk_now("trk_kick", 1, 0, 1);
        for (int i = 1; i < 8; i++) begin
            cyc(1, 0, 0, 0, 0);
            if (i == 6) chk_now("run7", -1, -1, 1);
        end
        chk_now("run8", -1, -1, 0);

        // Quiet and contradictory PD inputs hold the word and lead to lock.
        cyc(0, 0, 0, 1, 100);
        for (int i = 0; i < 20; i++) begin
            cyc(i % 2 == 0, i % 2 == 0, 0, 0, 0);
            if (i == 14) chk_now("quiet15", 100, 100, 0);
            if (i == 15) chk_now("quiet16", 100, 100, 1);
        end
        chk_now("quiet20", 100, 100, 1);

        // Holdover, then load overriding freeze.
        for (int i = 0; i < 10; i++) cyc(1, 0, 1, 0, 0);
        chk_now("freeze", 100, 100, 1);
        cyc(1, 0, 1, 1, 50); chk_now("load_frz", 50, 50, 0);

        // Randomized traffic in phases of different PD behaviour.
        for (int ph = 0; ph < 50; ph++) begin
            mode = int'($urandom_range(0, 4));
            for (int i = 0; i < 40; i++) begin
                case (mode)
                    0: begin u = 1'($urandom); d = 1'($urandom); end
                    1: begin u = (i % 2 == 0); d = (i % 2 == 1); end
                    2: begin u = 1'b1; d = ($urandom_range(0, 9) == 0); end
                    3: begin u = ($urandom_range(0, 9) == 0); d = 1'b1; end
                    default: begin u = 1'b0; d = ($urandom_range(0, 1) == 0) ? 1'b0 : 1'b0; end
                endcase
                f  = ($urandom_range(0, 19) == 0);
                l  = ($urandom_range(0, 49) == 0);
                lv = int'($urandom_range(0, 255));
                cyc(u, d, f, l, lv);
            end
            if (ph == 25) async_reset("rnd_rst");
        end

        cyc(0, 0, 0, 0, 0);
        repeat (3) @(posedge clk);
        #3;
        check("sb_drain", sbq.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
